lut_1557_scan: RTL and testbench

Sequential scanner that exhaustively reads back the `lut_1557` combinational lookup table in hardware. It drives the 4-bit code `b` through all 16 values and samples `s` after a programmable settle time. It assembles the observed 16-bit truth table and reports mismatch counts against an expected mask. It sits on the opposite side of the LUT's `b`→`s` interface, as a self-checking reader for board bring-up and BIST.

---
 rtl/lut_1557_scan_if.sv | 24 ++
 rtl/lut_1557_scan.sv | 145 ++++++++++++++
 tb/tb_lut_1557_scan.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/lut_1557_scan_if.sv
// Handshake and result bus between the LUT scanner and its requester.
// The requester drives start and the LUT output s; the scanner drives everything else.
interface lut_1557_scan_if;
   logic        start;
   logic        s;
   logic [3:0]  b;
   logic        busy;
   logic        done;
   logic [15:0] table_o;
   logic [4:0]  ones;
   logic [4:0]  err_one;
   logic [4:0]  err_zero;
   logic        pass;

   modport master (
      output start, s,
      input  b, busy, done, table_o, ones, err_one, err_zero, pass
   );

   modport slave (
      input  start, s,
      output b, busy, done, table_o, ones, err_one, err_zero, pass
   );
endinterface

// File: rtl/lut_1557_scan.sv
// Exhaustive reader for the lut_1557 table: steps b through all 16 codes, samples s
// after a settle delay, and scores the observed truth table against EXP_MASK.
module lut_1557_scan #(
   parameter int unsigned SETTLE_CYC = 2,
   parameter logic [15:0] EXP_MASK   = 16'h1557
) (
   input  logic           clk,
   input  logic           rst_n,
   lut_1557_scan_if.slave bus
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   // SETTLE lasts SETTLE_CYC cycles, counting the loaded value down to zero inclusive.
   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

   logic [1:0]  state_r,  state_s;
   logic [7:0]  cnt_r,    cnt_s;
   logic [3:0]  b_r,      b_s;
   logic        busy_r,   busy_s;
   logic        done_r,   done_s;
   logic [15:0] table_r,  table_s;
   logic [4:0]  ones_r,   ones_s;
   logic [4:0]  e1_r,     e1_s;
   logic [4:0]  e0_r,     e0_s;
   logic        pass_r,   pass_s;

   logic        exp_bit_s;
   logic [4:0]  ones_nx_s;
   logic [4:0]  e1_nx_s;
   logic [4:0]  e0_nx_s;

   // Score contribution of the code currently under test.
   always_comb begin
      exp_bit_s = EXP_MASK[b_r];
      ones_nx_s = ones_r + {4'd0, bus.s};
      e1_nx_s   = e1_r + {4'd0, (exp_bit_s & ~bus.s)};
      e0_nx_s   = e0_r + {4'd0, (~exp_bit_s & bus.s)};
   end

   // Next-state and next-output computation for the scan sequencer.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      b_s     = b_r;
      busy_s  = busy_r;
      done_s  = 1'b0;
      table_s = table_r;
      ones_s  = ones_r;
      e1_s    = e1_r;
      e0_s    = e0_r;
      pass_s  = pass_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               state_s = ST_SETTLE;
               cnt_s   = SETTLE_LOAD;
               b_s     = 4'd0;
               busy_s  = 1'b1;
               table_s = 16'd0;
               ones_s  = 5'd0;
               e1_s    = 5'd0;
               e0_s    = 5'd0;
               pass_s  = 1'b0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_r == 8'd0) begin
               state_s = ST_SAMPLE;
            end else begin
               cnt_s = cnt_r - 8'd1;
            end
         end
         ST_SAMPLE: begin
            table_s[b_r] = bus.s;
            ones_s       = ones_nx_s;
            e1_s         = e1_nx_s;
            e0_s         = e0_nx_s;
            // pass is taken from the final counts so it is valid together with done.
            if (b_r == 4'd15) begin
               state_s = ST_DONE;
               busy_s  = 1'b0;
               done_s  = 1'b1;
               pass_s  = (e1_nx_s == 5'd0) && (e0_nx_s == 5'd0);
            end else begin
               state_s = ST_SETTLE;
               cnt_s   = SETTLE_LOAD;
               b_s     = b_r + 4'd1;
            end
         end
         ST_DONE: begin
            state_s = ST_IDLE;
            b_s     = 4'd0;
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = 8'd0;
            b_s     = 4'd0;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any scan in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= 8'd0;
         b_r     <= 4'd0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         table_r <= 16'd0;
         ones_r  <= 5'd0;
         e1_r    <= 5'd0;
         e0_r    <= 5'd0;
         pass_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         b_r     <= b_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
         table_r <= table_s;
         ones_r  <= ones_s;
         e1_r    <= e1_s;
         e0_r    <= e0_s;
         pass_r  <= pass_s;
      end
   end

   assign bus.b        = b_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.table_o  = table_r;
   assign bus.ones     = ones_r;
   assign bus.err_one  = e1_r;
   assign bus.err_zero = e0_r;
   assign bus.pass     = pass_r;

endmodule

// File: tb/tb_lut_1557_scan.sv
// Directed bench for lut_1557_scan: table of LUT models with hand-computed results,
// plus sequences for busy-time start, mid-scan reset and a one-cycle settle time.
module tb_lut_1557_scan;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   lut_1557_scan_if bus_a ();
   lut_1557_scan_if bus_b ();

   lut_1557_scan dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   lut_1557_scan #(.SETTLE_CYC(1), .EXP_MASK(16'h1557)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   // 0: correct LUT, 1: stuck at 0, 2: stuck at 1, 3: code F flipped to 1
   logic [1:0] mode;

   function automatic logic lut_model(input logic [1:0] m, input logic [3:0] code);
      logic [15:0] t;
      case (m)
         2'd0:    t = 16'h1557;
         2'd1:    t = 16'h0000;
         2'd2:    t = 16'hFFFF;
         default: t = 16'h9557;
      endcase
      return t[code];
   endfunction

   assign bus_a.s = lut_model(mode, bus_a.b);
   assign bus_b.s = lut_model(mode, bus_b.b);

   logic        sel;
   logic [3:0]  b_v;
   logic        busy_v, done_v, pass_v;
   logic [15:0] tab_v;
   logic [4:0]  ones_v, e1_v, e0_v;

   always_comb begin
      if (sel) begin
         b_v = bus_b.b; busy_v = bus_b.busy; done_v = bus_b.done; pass_v = bus_b.pass;
         tab_v = bus_b.table_o; ones_v = bus_b.ones; e1_v = bus_b.err_one; e0_v = bus_b.err_zero;
      end else begin
         b_v = bus_a.b; busy_v = bus_a.busy; done_v = bus_a.done; pass_v = bus_a.pass;
         tab_v = bus_a.table_o; ones_v = bus_a.ones; e1_v = bus_a.err_one; e0_v = bus_a.err_zero;
      end
   end

   typedef struct {
      logic [1:0]  mode;
      logic [15:0] tab;
      logic [4:0]  ones;
      logic [4:0]  e1;
      logic [4:0]  e0;
      logic        pass;
   } vec_t;

   vec_t vecs [4];
   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, " b"}, 32'(b_v), 32'd0);
      chk({tag, " busy"}, 32'(busy_v), 32'd0);
      chk({tag, " done"}, 32'(done_v), 32'd0);
      chk({tag, " table"}, 32'(tab_v), 32'd0);
      chk({tag, " ones"}, 32'(ones_v), 32'd0);
      chk({tag, " err_one"}, 32'(e1_v), 32'd0);
      chk({tag, " err_zero"}, 32'(e0_v), 32'd0);
      chk({tag, " pass"}, 32'(pass_v), 32'd0);
   endtask

   task automatic do_scan(input vec_t v, input int settle);
      int hold, bad, nd;
      logic got;
      logic [3:0] prev;
      @(negedge clk);
      if (sel) bus_b.start = 1'b1; else bus_a.start = 1'b1;
      @(posedge clk); #1;
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      chk("start busy", 32'(busy_v), 32'd1);
      chk("start b", 32'(b_v), 32'd0);
      hold = 1; bad = 0; nd = 0; got = 1'b0; prev = b_v;
      for (int n = 1; n <= 200 && !got; n++) begin
         @(posedge clk); #1;
         if (done_v) begin
            got = 1'b1;
            nd  = n;
         end else if (b_v != prev) begin
            if (hold != settle + 1 || b_v != prev + 4'd1) bad++;
            hold = 1;
            prev = b_v;
         end else begin
            hold++;
         end
      end
      chk("done latency", 32'(nd), 32'(16 * (settle + 1)));
      chk("b hold pattern", 32'(bad), 32'd0);
      chk("b at done", 32'(b_v), 32'd15);
      chk("busy at done", 32'(busy_v), 32'd0);
      chk("table", 32'(tab_v), 32'(v.tab));
      chk("ones", 32'(ones_v), 32'(v.ones));
      chk("err_one", 32'(e1_v), 32'(v.e1));
      chk("err_zero", 32'(e0_v), 32'(v.e0));
      chk("pass", 32'(pass_v), 32'(v.pass));
      @(posedge clk); #1;
      chk("done one cycle", 32'(done_v), 32'd0);
      chk("b after done", 32'(b_v), 32'd0);
      chk("table held", 32'(tab_v), 32'(v.tab));
      chk("pass held", 32'(pass_v), 32'(v.pass));
   endtask

   initial begin
      int n7, spurious;
      logic found;
      vecs[0] = '{mode: 2'd0, tab: 16'h1557, ones: 5'd8,  e1: 5'd0, e0: 5'd0, pass: 1'b1};
      vecs[1] = '{mode: 2'd1, tab: 16'h0000, ones: 5'd0,  e1: 5'd8, e0: 5'd0, pass: 1'b0};
      vecs[2] = '{mode: 2'd2, tab: 16'hFFFF, ones: 5'd16, e1: 5'd0, e0: 5'd8, pass: 1'b0};
      vecs[3] = '{mode: 2'd3, tab: 16'h9557, ones: 5'd9,  e1: 5'd0, e0: 5'd1, pass: 1'b0};

      rst_n = 1'b0;
      bus_a.start = 1'b0;
      bus_b.start = 1'b0;
      mode = 2'd0;
      sel  = 1'b0;
      repeat (2) @(negedge clk);
      chk_zero_outputs("reset a");
      sel = 1'b1; #1;
      chk_zero_outputs("reset b");
      sel = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         mode = vecs[i].mode;
         do_scan(vecs[i], 2);
      end

      // Extra start while busy, then a one-cycle reset once b reaches 7.
      mode = 2'd0;
      @(negedge clk);
      bus_a.start = 1'b1;
      @(posedge clk); #1;
      bus_a.start = 1'b0;
      found = 1'b0; n7 = 0;
      for (int n = 1; n <= 100 && !found; n++) begin
         @(posedge clk); #1;
         bus_a.start = (n == 4);
         if (b_v == 4'd7) begin
            found = 1'b1;
            n7 = n;
         end
      end
      bus_a.start = 1'b0;
      chk("b reaches 7 despite extra start", 32'(n7), 32'd21);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_zero_outputs("mid-scan reset");
      @(negedge clk);
      rst_n = 1'b1;
      spurious = 0;
      for (int n = 0; n < 80; n++) begin
         @(posedge clk); #1;
         if (done_v || busy_v) spurious++;
      end
      chk("no activity after reset", 32'(spurious), 32'd0);
      do_scan(vecs[0], 2);

      // One-cycle settle instance, correct model.
      sel = 1'b1;
      do_scan(vecs[0], 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
